// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results.
// Ports: clk/rst; Pipe_* writeback in; Lu_* result in with Lu_Rdy; Wb_Stall; Rf_Wr* out; Fifo_Cnt.
module wb_port_arbiter #(
    parameter int DATA_W     = 128,
    parameter int RD_W       = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Pipe_Vld,
    input  logic [RD_W-1:0]            Pipe_Rd,
    input  logic [DATA_W-1:0]          Pipe_Data,
    input  logic                       Lu_Vld,
    input  logic [RD_W-1:0]            Lu_Rd,
    input  logic [DATA_W-1:0]          Lu_Data,
    output logic                       Lu_Rdy,
    output logic                       Wb_Stall,
    output logic                       Rf_WrEn,
    output logic [RD_W-1:0]            Rf_WrAddr,
    output logic [DATA_W-1:0]          Rf_WrData,
    output logic [$clog2(DEPTH):0]     Fifo_Cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]    SMAX = SW'(STARVE_MAX);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  r_vld;
    logic [RD_W-1:0]   r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [SW-1:0]     r_starve;
    logic              r_wr_en;
    logic [RD_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_empty;
    logic              w_full;
    logic              w_head_vld;
    logic              w_hreq;
    logic              w_force;
    logic              w_gnt_fifo;
    logic              w_gnt_pipe;
    logic              w_pop;
    logic              w_push;
    logic              w_wr_en;
    logic [DEPTH-1:0]  w_vld_nxt;

    always_comb begin
        w_empty    = (r_cnt == '0);
        w_full     = (r_cnt == FULL);
        w_head_vld = r_vld[r_rptr];
        w_hreq     = !w_empty && w_head_vld;
        w_force    = w_hreq && (r_starve == SMAX);
        w_gnt_fifo = w_force || (!Pipe_Vld && w_hreq);
        w_gnt_pipe = Pipe_Vld && !w_force;
        // A squashed head is discarded without using the write port.
        w_pop      = w_gnt_fifo || (!w_empty && !w_head_vld);
        w_push     = Lu_Vld && !w_full;
        w_wr_en    = 1'b0;
        if (w_gnt_fifo) begin
            w_wr_en = (r_rd[r_rptr] != '0);
        end else if (w_gnt_pipe) begin
            w_wr_en = (Pipe_Rd != '0);
        end
    end

    // Older queued results to the same register are superseded by the
    // pipeline write; the entry pushed this cycle is younger and survives
    // because the push is applied last.
    always_comb begin
        w_vld_nxt = r_vld;
        if (w_gnt_pipe && (Pipe_Rd != '0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_rd[i] == Pipe_Rd) begin
                    w_vld_nxt[i] = 1'b0;
                end
            end
        end
        if (w_pop) begin
            w_vld_nxt[r_rptr] = 1'b0;
        end
        if (w_push) begin
            w_vld_nxt[r_wptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (w_hreq && w_gnt_pipe && (r_starve != SMAX)) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= Lu_Rd;
            r_data[r_wptr] <= Lu_Data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_en;
            if (w_gnt_fifo) begin
                r_wr_addr <= r_rd[r_rptr];
                r_wr_data <= r_data[r_rptr];
            end else if (w_gnt_pipe) begin
                r_wr_addr <= Pipe_Rd;
                r_wr_data <= Pipe_Data;
            end
        end
    end

    assign Lu_Rdy    = !w_full;
    assign Wb_Stall  = w_force && Pipe_Vld;
    assign Rf_WrEn   = r_wr_en;
    assign Rf_WrAddr = r_wr_addr;
    assign Rf_WrData = r_wr_data;
    assign Fifo_Cnt  = r_cnt;

endmodule
